wifi_dma_scheduler: RTL and testbench

WIFI_DMA_SCHEDULER -- requirements
Module: wifi_dma_scheduler

---
 rtl/wifi_dma_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_wifi_dma_scheduler.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_dma_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wifi_dma_scheduler
//  Description : Arbitrates DMA refill of the TX FIFO and DMA drain of the RX
//                FIFO. Round-robin between the two sides, with RX overflow
//                priority, per-transfer watchdog and frame interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module wifi_dma_scheduler #(
    parameter int FIFO_DEPTH = 128,
    parameter int CNT_W      = 8,
    parameter int BURST_LEN  = 16,
    parameter int TX_LOW_WM  = 32,
    parameter int RX_HIGH_WM = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic             HCLK,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] tx_count,
    input  logic [CNT_W-1:0] rx_count,
    input  logic             tx_frame_end,
    input  logic             rx_frame_end,
    input  logic [1:0]       irq_clr,
    input  logic             DMA_WRITE_ACK,
    input  logic             DMA_WRITE_DONE,
    input  logic             DMA_READ_ACK,
    input  logic             DMA_READ_DONE,
    output logic             DMA_WRITE_REQ,
    output logic             DMA_READ_REQ,
    output logic             Tx_irq,
    output logic             rx_irq,
    output logic             busy,
    output logic             timeout_err
);

    // Watchdog counter only has to reach TIMEOUT-1
    localparam int                c_WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST    = c_WD_W'(TIMEOUT - 1);
    localparam logic [31:0]       c_FIFO_DEPTH = 32'(FIFO_DEPTH);
    localparam logic [31:0]       c_BURST_LEN  = 32'(BURST_LEN);
    localparam logic [31:0]       c_TX_LOW_WM  = 32'(TX_LOW_WM);
    localparam logic [31:0]       c_RX_HIGH_WM = 32'(RX_HIGH_WM);
    localparam logic [31:0]       c_OVF_LVL    = 32'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_REQ  = 3'd1,
        ST_TX_XFER = 3'd2,
        ST_RX_REQ  = 3'd3,
        ST_RX_XFER = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WD_W-1:0]   r_wd;
    logic [c_WD_W-1:0]   w_wd_nxt;
    logic                r_last_rx;        // 0: last grant went to TX, 1: to RX
    logic                r_rx_pend;
    logic                r_tx_frame_seen;
    logic                w_grant_tx;
    logic                w_grant_rx;
    logic                w_timeout_hit;
    logic [31:0]         w_tx_ext;
    logic [31:0]         w_rx_ext;
    logic                w_tx_need;
    logic                w_rx_need;
    logic                w_rx_ovf;
    logic                w_tx_seen;
    logic                w_tx_irq_set;

    assign w_tx_ext = 32'(tx_count);
    assign w_rx_ext = 32'(rx_count);

    // "Free space >= burst" is written as count + burst <= depth to stay unsigned
    assign w_tx_need = enable && (w_tx_ext < c_TX_LOW_WM)
                              && ((w_tx_ext + c_BURST_LEN) <= c_FIFO_DEPTH);
    assign w_rx_need = enable && ((w_rx_ext >= c_RX_HIGH_WM)
                              || (r_rx_pend && (rx_count != '0)));
    assign w_rx_ovf  = (w_rx_ext >= c_OVF_LVL);

    // A frame end stays latched until the TX FIFO has fully emptied
    assign w_tx_seen    = r_tx_frame_seen | tx_frame_end;
    assign w_tx_irq_set = w_tx_seen && (tx_count == '0);

    // Next-state, grant selection and watchdog update
    always_comb begin
        w_state_nxt   = r_state;
        w_wd_nxt      = r_wd;
        w_grant_tx    = 1'b0;
        w_grant_rx    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_need && w_rx_ovf) begin
                    w_grant_rx = 1'b1;
                end else if (w_tx_need && w_rx_need) begin
                    if (r_last_rx) begin
                        w_grant_tx = 1'b1;
                    end else begin
                        w_grant_rx = 1'b1;
                    end
                end else if (w_tx_need) begin
                    w_grant_tx = 1'b1;
                end else if (w_rx_need) begin
                    w_grant_rx = 1'b1;
                end
                if (w_grant_tx) begin
                    w_state_nxt = ST_TX_REQ;
                end else if (w_grant_rx) begin
                    w_state_nxt = ST_RX_REQ;
                end
            end
            ST_TX_REQ: begin
                if (DMA_WRITE_DONE) begin
                    w_state_nxt = ST_IDLE;
                end else if (DMA_WRITE_ACK) begin
                    w_state_nxt = ST_TX_XFER;
                    w_wd_nxt    = '0;
                end
            end
            ST_TX_XFER: begin
                if (DMA_WRITE_DONE) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wd == c_WD_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            ST_RX_REQ: begin
                if (DMA_READ_DONE) begin
                    w_state_nxt = ST_IDLE;
                end else if (DMA_READ_ACK) begin
                    w_state_nxt = ST_RX_XFER;
                    w_wd_nxt    = '0;
                end
            end
            ST_RX_XFER: begin
                if (DMA_READ_DONE) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wd == c_WD_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and watchdog registers
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Round-robin history and pending RX frame (a new frame end beats the clear)
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            r_last_rx <= 1'b0;
            r_rx_pend <= 1'b0;
        end else begin
            if (w_grant_tx) begin
                r_last_rx <= 1'b0;
            end else if (w_grant_rx) begin
                r_last_rx <= 1'b1;
            end
            if (rx_frame_end) begin
                r_rx_pend <= 1'b1;
            end else if (w_grant_rx) begin
                r_rx_pend <= 1'b0;
            end
        end
    end

    // Frame interrupts: a set in the same cycle as its clear wins
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            r_tx_frame_seen <= 1'b0;
            Tx_irq          <= 1'b0;
            rx_irq          <= 1'b0;
        end else begin
            if (w_tx_irq_set) begin
                r_tx_frame_seen <= 1'b0;
                Tx_irq          <= 1'b1;
            end else begin
                r_tx_frame_seen <= w_tx_seen;
                if (irq_clr[0]) begin
                    Tx_irq <= 1'b0;
                end
            end
            if (rx_frame_end) begin
                rx_irq <= 1'b1;
            end else if (irq_clr[1]) begin
                rx_irq <= 1'b0;
            end
        end
    end

    // Registered handshake/status outputs decoded from the upcoming state
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            DMA_WRITE_REQ <= 1'b0;
            DMA_READ_REQ  <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            DMA_WRITE_REQ <= (w_state_nxt == ST_TX_REQ);
            DMA_READ_REQ  <= (w_state_nxt == ST_RX_REQ);
            busy          <= (w_state_nxt != ST_IDLE);
            timeout_err   <= timeout_err | w_timeout_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wifi_dma_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wifi_dma_scheduler
//  Description : Self-checking bench for wifi_dma_scheduler (directed
//                scenarios plus randomized traffic against a behavioural model)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wifi_dma_scheduler;

    localparam int FIFO_DEPTH = 128;
    localparam int BURST_LEN  = 16;
    localparam int TX_LOW_WM  = 32;
    localparam int RX_HIGH_WM = 32;
    localparam int TIMEOUT    = 1024;

    logic       HCLK = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] tx_count = '0;
    logic [7:0] rx_count = '0;
    logic       tx_frame_end = 1'b0;
    logic       rx_frame_end = 1'b0;
    logic [1:0] irq_clr = '0;
    logic       DMA_WRITE_ACK = 1'b0;
    logic       DMA_WRITE_DONE = 1'b0;
    logic       DMA_READ_ACK = 1'b0;
    logic       DMA_READ_DONE = 1'b0;
    logic       DMA_WRITE_REQ;
    logic       DMA_READ_REQ;
    logic       Tx_irq;
    logic       rx_irq;
    logic       busy;
    logic       timeout_err;
    logic [5:0] outs;

    int checks = 0;
    int failures = 0;

    // Behavioural model: owner 0 none, 1 TX, 2 RX; acked = handshake accepted
    int m_owner, m_acked, m_cycles;
    bit m_last_rx, m_pend, m_latch, m_txirq, m_rxirq, m_terr;

    wifi_dma_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(8), .BURST_LEN(BURST_LEN),
        .TX_LOW_WM(TX_LOW_WM), .RX_HIGH_WM(RX_HIGH_WM), .TIMEOUT(TIMEOUT)
    ) dut (
        .HCLK(HCLK), .reset(reset), .enable(enable),
        .tx_count(tx_count), .rx_count(rx_count),
        .tx_frame_end(tx_frame_end), .rx_frame_end(rx_frame_end),
        .irq_clr(irq_clr),
        .DMA_WRITE_ACK(DMA_WRITE_ACK), .DMA_WRITE_DONE(DMA_WRITE_DONE),
        .DMA_READ_ACK(DMA_READ_ACK), .DMA_READ_DONE(DMA_READ_DONE),
        .DMA_WRITE_REQ(DMA_WRITE_REQ), .DMA_READ_REQ(DMA_READ_REQ),
        .Tx_irq(Tx_irq), .rx_irq(rx_irq), .busy(busy), .timeout_err(timeout_err)
    );

    // {write_req, read_req, busy, tx_irq, rx_irq, timeout_err}
    assign outs = {DMA_WRITE_REQ, DMA_READ_REQ, busy, Tx_irq, rx_irq, timeout_err};

    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit reached, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic clear_inputs();
        enable = 1'b0; tx_count = '0; rx_count = '0;
        tx_frame_end = 1'b0; rx_frame_end = 1'b0; irq_clr = '0;
        DMA_WRITE_ACK = 1'b0; DMA_WRITE_DONE = 1'b0;
        DMA_READ_ACK = 1'b0; DMA_READ_DONE = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Steps until a request appears (bounded); side 1 = TX, 2 = RX, 0 = none
    task automatic wait_grant(output int side);
        side = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (DMA_WRITE_REQ) begin side = 1; break; end
            if (DMA_READ_REQ)  begin side = 2; break; end
        end
    endtask

    task automatic finish_xfer(input int side);
        if (side == 1) DMA_WRITE_ACK = 1'b1; else DMA_READ_ACK = 1'b1;
        step();
        DMA_WRITE_ACK = 1'b0; DMA_READ_ACK = 1'b0;
        if (side == 1) DMA_WRITE_DONE = 1'b1; else DMA_READ_DONE = 1'b1;
        step();
        DMA_WRITE_DONE = 1'b0; DMA_READ_DONE = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 reset = 1'b1;
        #2;
        checks++;
        if (outs !== 6'b000000) begin
            failures++; $display("FAIL reset_async got=%b exp=%b", outs, 6'b000000);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (outs !== 6'b000000) begin
            failures++; $display("FAIL reset_release got=%b exp=%b", outs, 6'b000000);
        end
    endtask

    task automatic test_tx_basic();
        apply_reset();
        DMA_WRITE_ACK = 1'b1; DMA_WRITE_DONE = 1'b1; DMA_READ_ACK = 1'b1;
        step();
        checks++;
        if (outs !== 6'b000000) begin
            failures++; $display("FAIL idle_ignores_handshake got=%b exp=%b", outs, 6'b000000);
        end
        clear_inputs();
        enable = 1'b1; tx_count = 8'd10; rx_count = 8'd0;
        step();
        checks++;
        if (outs !== 6'b101000) begin
            failures++; $display("FAIL tx_grant got=%b exp=%b", outs, 6'b101000);
        end
        DMA_READ_ACK = 1'b1; DMA_READ_DONE = 1'b1;
        step();
        checks++;
        if (outs !== 6'b101000) begin
            failures++; $display("FAIL tx_req_hold_other_chan got=%b exp=%b", outs, 6'b101000);
        end
        DMA_READ_ACK = 1'b0; DMA_READ_DONE = 1'b0;
        DMA_WRITE_ACK = 1'b1;
        step();
        checks++;
        if (outs !== 6'b001000) begin
            failures++; $display("FAIL tx_ack_req_drop got=%b exp=%b", outs, 6'b001000);
        end
        DMA_WRITE_ACK = 1'b0; DMA_WRITE_DONE = 1'b1;
        step();
        checks++;
        if (outs !== 6'b000000) begin
            failures++; $display("FAIL tx_done_idle got=%b exp=%b", outs, 6'b000000);
        end
        DMA_WRITE_DONE = 1'b0;
        step();
        checks++;
        if (outs !== 6'b101000) begin
            failures++; $display("FAIL tx_regrant_after_idle got=%b exp=%b", outs, 6'b101000);
        end
        DMA_WRITE_DONE = 1'b1;
        step();
        checks++;
        if (outs !== 6'b000000) begin
            failures++; $display("FAIL done_in_req got=%b exp=%b", outs, 6'b000000);
        end
        DMA_WRITE_DONE = 1'b0; enable = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int side;
        apply_reset();
        enable = 1'b1; tx_count = 8'd40; rx_count = 8'd40;
        wait_grant(side);
        checks++;
        if (side != 2) begin
            failures++; $display("FAIL rr_rx_only side=%0d exp=%0d", side, 2);
        end
        finish_xfer(2);
        tx_count = 8'd10;
        for (int k = 0; k < 4; k++) begin
            wait_grant(side);
            checks++;
            if (side != ((k % 2 == 0) ? 1 : 2)) begin
                failures++; $display("FAIL rr_alternate idx=%0d side=%0d exp=%0d", k, side, (k % 2 == 0) ? 1 : 2);
            end
            finish_xfer((side == 0) ? 1 : side);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        int side;
        apply_reset();
        enable = 1'b1; tx_count = 8'd40; rx_count = 8'd40;
        wait_grant(side);
        finish_xfer(2);
        tx_count = 8'd0; rx_count = 8'd40;
        wait_grant(side);
        checks++;
        if (side != 1) begin
            failures++; $display("FAIL rr_no_overflow side=%0d exp=%0d", side, 1);
        end
        finish_xfer(1);
        wait_grant(side);
        finish_xfer(2);
        rx_count = 8'd115;
        wait_grant(side);
        checks++;
        if (side != 2) begin
            failures++; $display("FAIL overflow_priority side=%0d exp=%0d", side, 2);
        end
        enable = 1'b0;
        finish_xfer(2);
    endtask

    task automatic test_timeout();
        int side;
        apply_reset();
        enable = 1'b1; tx_count = 8'd10;
        wait_grant(side);
        DMA_WRITE_ACK = 1'b1;
        step();
        DMA_WRITE_ACK = 1'b0; enable = 1'b0;
        repeat (TIMEOUT - 1) step();
        checks++;
        if (outs !== 6'b001000) begin
            failures++; $display("FAIL timeout_still_xfer got=%b exp=%b", outs, 6'b001000);
        end
        step();
        checks++;
        if (outs !== 6'b000001) begin
            failures++; $display("FAIL timeout_fire got=%b exp=%b", outs, 6'b000001);
        end
        repeat (5) step();
        checks++;
        if (outs !== 6'b000001) begin
            failures++; $display("FAIL timeout_sticky got=%b exp=%b", outs, 6'b000001);
        end
    endtask

    task automatic test_irq();
        apply_reset();
        enable = 1'b1; tx_count = 8'd40; rx_count = 8'd5;
        rx_frame_end = 1'b1;
        step();
        checks++;
        if (outs !== 6'b000010) begin
            failures++; $display("FAIL rx_irq_set got=%b exp=%b", outs, 6'b000010);
        end
        rx_frame_end = 1'b0;
        step();
        checks++;
        if (outs !== 6'b011010) begin
            failures++; $display("FAIL rx_pend_grant got=%b exp=%b", outs, 6'b011010);
        end
        rx_frame_end = 1'b1; irq_clr = 2'b10;
        step();
        checks++;
        if (outs !== 6'b011010) begin
            failures++; $display("FAIL rx_irq_set_wins got=%b exp=%b", outs, 6'b011010);
        end
        rx_frame_end = 1'b0;
        step();
        checks++;
        if (outs !== 6'b011000) begin
            failures++; $display("FAIL rx_irq_clear got=%b exp=%b", outs, 6'b011000);
        end
        irq_clr = 2'b00; enable = 1'b0;
        finish_xfer(2);
        tx_count = 8'd5; tx_frame_end = 1'b1;
        step();
        tx_frame_end = 1'b0;
        step();
        checks++;
        if (outs !== 6'b000000) begin
            failures++; $display("FAIL tx_irq_wait_empty got=%b exp=%b", outs, 6'b000000);
        end
        tx_count = 8'd0;
        step();
        checks++;
        if (outs !== 6'b000100) begin
            failures++; $display("FAIL tx_irq_set got=%b exp=%b", outs, 6'b000100);
        end
        irq_clr = 2'b01;
        step();
        checks++;
        if (outs !== 6'b000000) begin
            failures++; $display("FAIL tx_irq_clear got=%b exp=%b", outs, 6'b000000);
        end
        irq_clr = 2'b00;
    endtask

    task automatic test_reset_mid_xfer();
        apply_reset();
        enable = 1'b1; tx_count = 8'd10; rx_frame_end = 1'b1;
        step();
        rx_frame_end = 1'b0; DMA_WRITE_ACK = 1'b1;
        step();
        DMA_WRITE_ACK = 1'b0;
        step();
        checks++;
        if (outs !== 6'b001010) begin
            failures++; $display("FAIL pre_reset_xfer got=%b exp=%b", outs, 6'b001010);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (outs !== 6'b000000) begin
            failures++; $display("FAIL reset_mid_async got=%b exp=%b", outs, 6'b000000);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (outs !== 6'b101000) begin
            failures++; $display("FAIL regrant_after_reset got=%b exp=%b", outs, 6'b101000);
        end
        enable = 1'b0; DMA_WRITE_DONE = 1'b1;
        step();
        DMA_WRITE_DONE = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int  t, r;
        bit  tneed, rneed, grant_rx, ack, done, seen;
        t = int'(tx_count);
        r = int'(rx_count);
        tneed = enable && (t < TX_LOW_WM) && ((FIFO_DEPTH - t) >= BURST_LEN);
        rneed = enable && ((r >= RX_HIGH_WM) || (m_pend && r != 0));
        grant_rx = 1'b0;
        if (m_owner == 0) begin
            if (rneed && r >= FIFO_DEPTH - BURST_LEN)      m_owner = 2;
            else if (tneed && rneed)                       m_owner = m_last_rx ? 1 : 2;
            else if (tneed)                                m_owner = 1;
            else if (rneed)                                m_owner = 2;
            if (m_owner != 0) begin
                m_acked = 0;
                m_last_rx = (m_owner == 2);
                grant_rx = (m_owner == 2);
            end
        end else begin
            ack  = (m_owner == 1) ? DMA_WRITE_ACK  : DMA_READ_ACK;
            done = (m_owner == 1) ? DMA_WRITE_DONE : DMA_READ_DONE;
            if (done) begin
                m_owner = 0;
            end else if (m_acked == 0) begin
                if (ack) begin m_acked = 1; m_cycles = 0; end
            end else begin
                m_cycles++;
                if (m_cycles == TIMEOUT) begin m_owner = 0; m_terr = 1'b1; end
            end
        end
        if (rx_frame_end) m_pend = 1'b1;
        else if (grant_rx) m_pend = 1'b0;
        seen = m_latch || tx_frame_end;
        if (seen && t == 0) begin
            m_txirq = 1'b1; m_latch = 1'b0;
        end else begin
            m_latch = seen;
            if (irq_clr[0]) m_txirq = 1'b0;
        end
        if (rx_frame_end) m_rxirq = 1'b1;
        else if (irq_clr[1]) m_rxirq = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] exp;
        apply_reset();
        m_owner = 0; m_acked = 0; m_cycles = 0;
        m_last_rx = 1'b0; m_pend = 1'b0; m_latch = 1'b0;
        m_txirq = 1'b0; m_rxirq = 1'b0; m_terr = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                tx_count = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
            if ($urandom_range(0, 3) == 0)
                rx_count = 8'($urandom_range(0, 127));
            tx_frame_end   = ($urandom_range(0, 9) == 0);
            rx_frame_end   = ($urandom_range(0, 9) == 0);
            irq_clr        = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            DMA_WRITE_ACK  = ($urandom_range(0, 3) == 0);
            DMA_WRITE_DONE = ($urandom_range(0, 5) == 0);
            DMA_READ_ACK   = ($urandom_range(0, 3) == 0);
            DMA_READ_DONE  = ($urandom_range(0, 5) == 0);
            model_step();
            step();
            exp = {(m_owner == 1 && m_acked == 0), (m_owner == 2 && m_acked == 0),
                   (m_owner != 0), m_txirq, m_rxirq, m_terr};
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("FAIL random_cycle n=%0d got=%b exp=%b", n, outs, exp);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_round_robin();
        test_overflow();
        test_timeout();
        test_irq();
        test_reset_mid_xfer();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
